mlp_xor_seq: RTL and testbench
==============================

Name: mlp_xor_seq

Overview:
- Sequential, parametrised fixed-point 2-2-1 perceptron network: two hidden neurons feed one output neuron.
- Intended for XOR evaluation and any other two-input logic function.
- A single shared multiply-accumulate unit is time-multiplexed over six MAC steps per sample.
- Nine programmable weights in a register file; valid/ready streaming on input and output.
- Next generation of the combinational XOR neuron pair: adds configurable format and activation threshold, weight storage, flow control and exposed hidden outputs.

Parameters:
- W, 16, total word width, signed two's complement.
- FW, 12, fraction bits; 1.0 = 1<<FW (0x1000 at defaults).
- ACT_GE, 0, activation rule: 0 fires when acc > 0; 1 fires when acc >= 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  weight write strobe.
- cfg_addr  in  4  weight index 0..8: 0 b1, 1 w11, 2 w21, 3 b2, 4 w12, 5 w22, 6 b0, 7 w1, 8 w2.
- cfg_wdata  in  W  weight value.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- x1  in  W  input 1.
- x2  in  W  input 2.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- y  out  1  output neuron result.
- h1  out  1  hidden neuron 1 result.
- h2  out  1  hidden neuron 2 result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert): all nine weights, y, h1, h2, out_valid, busy and the accumulator go to 0; state goes to IDLE; in_ready = 1 after reset. Reset mid-sample aborts the sample; no out_valid is produced for it.
- Weight writes:
  - Write takes effect on the clk edge where cfg_we = 1, state is IDLE and cfg_addr <= 8.
  - Writes at any other time, or with cfg_addr 9..15, are dropped silently.
  - A write and a sample accept in the same IDLE cycle are both performed; the sample is computed with the new weight.
- Arithmetic:
  - Accumulator width 2W+2, in Q(.,2FW).
  - Bias enters as sign-extended bias << FW; each product is the exact signed W x W product.
  - No truncation, no overflow possible; activation is decided on the full accumulator sign and zero value.
- Hidden values fed to the output neuron: hv = h ? (1<<FW) : 0.
- FSM states: IDLE, MAC, OUT. Step counter s runs 0..5 in MAC.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch x1 and x2, set s = 0, go to MAC.
- MAC schedule, one step per cycle:
  - s0: acc = b1<<FW + w11*x1.
  - s1: acc += w21*x2; h1 = act(acc).
  - s2: acc = b2<<FW + w12*x1.
  - s3: acc += w22*x2; h2 = act(acc).
  - s4: acc = b0<<FW + w1*h1v.
  - s5: acc += w2*h2v; y = act(acc); go to OUT.
- OUT:
  - out_valid = 1.
  - y, h1, h2 held stable until out_ready = 1, then return to IDLE.
  - in_ready = 0 in OUT; no overlap between samples.
- Latency: accept on edge k gives out_valid high after edge k+6. With out_ready held high, peak throughput is one sample per 8 cycles.
- Outputs h1, h2, y change only at their MAC steps or reset; they are not cleared on returning to IDLE.
- in_valid while busy is ignored; it is not queued.

Test Plan:
- Reset then idle: rst pulse mid-operation -> out_valid=0, y=h1=h2=0, in_ready=1, busy=0; a subsequent read of any sample with zero weights gives y=0 (ACT_GE=0).
- XOR at defaults:
  - Weights: b1=0xF800, w11=w21=0x1000, b2=0x1800, w12=w22=0xF000, b0=0xE800, w1=w2=0x1000.
  - Inputs (0,0), (0,0x1000), (0x1000,0), (0x1000,0x1000) -> y = 0,1,1,0; (h1,h2) = (0,1),(1,1),(1,1),(1,0).
  - out_valid rises exactly 6 edges after each accept.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> y stable, in_ready=0, second in_valid ignored; release -> IDLE next edge, in_ready=1.
- Config guards:
  - Write w11=0x7FFF while busy -> dropped; next sample uses the old value.
  - Write cfg_addr=9 -> no weight changes.
  - Write together with accept in IDLE -> new value used.
- Activation boundary: all weights 0, x=(0x1000,0x1000) -> acc=0; ACT_GE=0 gives y=h1=h2=0; ACT_GE=1 gives y=h1=h2=1.
- Extremes: x1=x2=0x8000, w11=w21=0x8000, b1=0x7FFF -> no overflow, h1=1 for both ACT_GE settings.

Source files
------------

// File: rtl/mlp_xor_seq_if.sv
// Streaming and configuration bundle for the 2-2-1 perceptron.
// The bench drives the master side; the network is the slave.
interface mlp_xor_seq_if #(
    parameter int W = 16
);
    logic         cfg_we;
    logic [3:0]   cfg_addr;
    logic [W-1:0] cfg_wdata;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         out_valid;
    logic         out_ready;
    logic         y;
    logic         h1;
    logic         h2;
    logic         busy;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        output in_valid, x1, x2, out_ready,
        input  in_ready, out_valid, y, h1, h2, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        input  in_valid, x1, x2, out_ready,
        output in_ready, out_valid, y, h1, h2, busy
    );
endinterface

// File: rtl/mlp_xor_seq.sv
// Sequential fixed-point 2-2-1 perceptron network.
// One shared MAC unit is stepped six times per sample.
module mlp_xor_seq #(
    parameter int W      = 16,
    parameter int FW     = 12,
    parameter bit ACT_GE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    mlp_xor_seq_if.slave bus
);
    localparam int AW = 2 * W + 2;
    localparam logic signed [W-1:0] ONE = W'(1) << FW;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state;
    state_t state_nx;

    logic        [2:0]    step;
    logic signed [W-1:0]  wt [9];
    logic signed [W-1:0]  xa;
    logic signed [W-1:0]  xb;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_nx;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] base;
    logic signed [W-1:0]  op_w;
    logic signed [W-1:0]  op_x;
    logic signed [W-1:0]  op_b;
    logic                 clr;
    logic                 fire;
    logic                 y_r;
    logic                 h1_r;
    logic                 h2_r;

    // Select weight, operand and bias for the current MAC step.
    always_comb begin
        op_w = '0;
        op_x = '0;
        op_b = '0;
        clr  = 1'b0;
        unique case (step)
            3'd0: begin
                op_w = wt[1];
                op_x = xa;
                op_b = wt[0];
                clr  = 1'b1;
            end
            3'd1: begin
                op_w = wt[2];
                op_x = xb;
            end
            3'd2: begin
                op_w = wt[4];
                op_x = xa;
                op_b = wt[3];
                clr  = 1'b1;
            end
            3'd3: begin
                op_w = wt[5];
                op_x = xb;
            end
            3'd4: begin
                op_w = wt[7];
                op_x = h1_r ? ONE : '0;
                op_b = wt[6];
                clr  = 1'b1;
            end
            3'd5: begin
                op_w = wt[8];
                op_x = h2_r ? ONE : '0;
            end
            default: begin
                op_w = '0;
            end
        endcase
    end

    // Exact product plus either the running sum or the scaled bias.
    always_comb begin
        prod   = AW'(op_w) * AW'(op_x);
        base   = clr ? (AW'(op_b) <<< FW) : acc;
        acc_nx = base + prod;
        if (ACT_GE)
            fire = ~acc_nx[AW-1];
        else
            fire = ~acc_nx[AW-1] & (acc_nx != '0);
    end

    // Weight file; only writable while idle and for indices 0..8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++)
                wt[i] <= '0;
        end else if (bus.cfg_we && state == IDLE
                     && bus.cfg_addr <= 4'd8) begin
            wt[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid)
                    state_nx = MAC;
            end
            MAC: begin
                if (step == 3'd5)
                    state_nx = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Input latch, step counter, accumulator and neuron results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xa   <= '0;
            xb   <= '0;
            step <= '0;
            acc  <= '0;
            y_r  <= 1'b0;
            h1_r <= 1'b0;
            h2_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xa   <= bus.x1;
                        xb   <= bus.x2;
                        step <= '0;
                    end
                end
                MAC: begin
                    acc  <= acc_nx;
                    step <= step + 3'd1;
                    if (step == 3'd1)
                        h1_r <= fire;
                    if (step == 3'd3)
                        h2_r <= fire;
                    if (step == 3'd5)
                        y_r <= fire;
                end
                default: begin
                    step <= step;
                end
            endcase
        end
    end

    assign bus.y  = y_r;
    assign bus.h1 = h1_r;
    assign bus.h2 = h2_r;
endmodule

// File: tb/tb_mlp_xor_seq.sv
// Scoreboard bench for mlp_xor_seq.
// Two instances (ACT_GE 0 and 1) run the same stimulus in lockstep.
module tb_mlp_xor_seq;
    localparam int W  = 16;
    localparam int FW = 12;

    typedef struct packed {
        logic y;
        logic h1;
        logic h2;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_addr = '0;
    logic [W-1:0] cfg_wdata = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] x1 = '0;
    logic [W-1:0] x2 = '0;
    logic         out_ready = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] wm [9];
    res_t q0 [$];
    res_t q1 [$];
    res_t e0;
    res_t e1;

    mlp_xor_seq_if #(.W(W)) ifa ();
    mlp_xor_seq_if #(.W(W)) ifb ();

    assign ifa.cfg_we    = cfg_we;
    assign ifa.cfg_addr  = cfg_addr;
    assign ifa.cfg_wdata = cfg_wdata;
    assign ifa.in_valid  = in_valid;
    assign ifa.x1        = x1;
    assign ifa.x2        = x2;
    assign ifa.out_ready = out_ready;
    assign ifb.cfg_we    = cfg_we;
    assign ifb.cfg_addr  = cfg_addr;
    assign ifb.cfg_wdata = cfg_wdata;
    assign ifb.in_valid  = in_valid;
    assign ifb.x1        = x1;
    assign ifb.x2        = x2;
    assign ifb.out_ready = out_ready;

    mlp_xor_seq #(.W(W), .FW(FW), .ACT_GE(1'b0)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(ifa.slave)
    );

    mlp_xor_seq #(.W(W), .FW(FW), .ACT_GE(1'b1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic logic act(input longint a, input bit ge);
        return ge ? (a >= 0) : (a > 0);
    endfunction

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic res_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input bit ge);
        longint one;
        longint s;
        res_t   r;
        one  = longint'(1) << FW;
        s    = sx(wm[0]) * one + sx(wm[1]) * sx(a) + sx(wm[2]) * sx(b);
        r.h1 = act(s, ge);
        s    = sx(wm[3]) * one + sx(wm[4]) * sx(a) + sx(wm[5]) * sx(b);
        r.h2 = act(s, ge);
        s    = sx(wm[6]) * one + sx(wm[7]) * (r.h1 ? one : 0)
             + sx(wm[8]) * (r.h2 ? one : 0);
        r.y  = act(s, ge);
        return r;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_vld"}, ifa.out_valid, 0);
        chk({tag, "_rdy"}, ifa.in_ready, 1);
        chk({tag, "_busy"}, ifa.busy, 0);
        chk({tag, "_y"}, {ifa.y, ifa.h1, ifa.h2}, 0);
        chk({tag, "_y1"}, {ifb.y, ifb.h1, ifb.h2}, 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [W-1:0] d,
                      input bit takes);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        if (takes && a <= 4'd8)
            wm[a] = d;
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit do_wr, input logic [3:0] wa,
                         input logic [W-1:0] wd);
        @(negedge clk);
        for (int i = 0; i < 50 && !ifa.in_ready; i++)
            @(negedge clk);
        chk("start_rdy", ifa.in_ready, 1);
        if (do_wr) begin
            cfg_we    = 1'b1;
            cfg_addr  = wa;
            cfg_wdata = wd;
            if (wa <= 4'd8)
                wm[wa] = wd;
        end
        in_valid = 1'b1;
        x1       = a;
        x2       = b;
        q0.push_back(model(a, b, 1'b0));
        q1.push_back(model(a, b, 1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic wait_out(input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 20 && !ifa.out_valid) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !ifa.in_ready; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        start(a, b, 1'b0, 4'd0, '0);
        wait_out(6);
        wait_idle();
    endtask

    // Scoreboard: compare every completed output handshake.
    always @(negedge clk) begin
        if (!rst && ifa.out_valid && ifa.out_ready) begin
            chk("sb0_avail", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("sb0_res", {ifa.y, ifa.h1, ifa.h2}, e0);
            end
        end
        if (!rst && ifb.out_valid && ifb.out_ready) begin
            chk("sb1_avail", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("sb1_res", {ifb.y, ifb.h1, ifb.h2}, e1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        res_t ebp;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 9; i++)
            wm[i] = '0;
        #12;
        check_idle("rst0");
        rst = 1'b0;

        wr(4'd0, 16'hF800, 1'b1);
        wr(4'd1, 16'h1000, 1'b1);
        wr(4'd2, 16'h1000, 1'b1);
        wr(4'd3, 16'h1800, 1'b1);
        wr(4'd4, 16'hF000, 1'b1);
        wr(4'd5, 16'hF000, 1'b1);
        wr(4'd6, 16'hE800, 1'b1);
        wr(4'd7, 16'h1000, 1'b1);
        wr(4'd8, 16'h1000, 1'b1);

        for (int i = 0; i < 4; i++) begin
            a = (i >= 2) ? 16'h1000 : 16'h0000;
            b = (i % 2 == 1) ? 16'h1000 : 16'h0000;
            run(a, b);
            chk("xor_y", ifa.y, (i == 1 || i == 2));
            chk("xor_h1", ifa.h1, (i != 0));
            chk("xor_h2", ifa.h2, (i != 3));
        end

        start(16'h0400, 16'h0000, 1'b0, 4'd0, '0);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = 4'd1;
        cfg_wdata = 16'h7FFF;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        wait_out(5);
        wait_idle();
        run(16'h0400, 16'h0000);
        chk("busy_wr_h1", ifa.h1, 0);

        wr(4'd9, 16'h7FFF, 1'b0);
        run(16'h0400, 16'h0400);
        chk("addr9_h1", ifa.h1, 0);

        start(16'h0400, 16'h0000, 1'b1, 4'd1, 16'h7FFF);
        wait_out(6);
        wait_idle();
        chk("wr_acc_h1", ifa.h1, 1);

        out_ready = 1'b0;
        ebp = model(16'h1000, 16'h0000, 1'b0);
        start(16'h1000, 16'h0000, 1'b0, 4'd0, '0);
        wait_out(6);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1;
                x1       = 16'h0000;
                x2       = 16'h0000;
            end
            if (i == 6)
                in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_res", {ifa.y, ifa.h1, ifa.h2}, ebp);
            chk("bp_rdy", ifa.in_ready, 0);
            chk("bp_vld", ifa.out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_rdy", ifa.in_ready, 1);
        chk("bp_rel_busy", ifa.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ignored", ifa.busy, 0);

        start(16'h1000, 16'h1000, 1'b0, 4'd0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_idle("rst_mid");
        q0.delete();
        q1.delete();
        for (int i = 0; i < 9; i++)
            wm[i] = '0;
        #3 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_no_out", ifa.out_valid, 0);

        run(16'h1000, 16'h1000);
        chk("zero_ge0", {ifa.y, ifa.h1, ifa.h2}, 3'b000);
        chk("zero_ge1", {ifb.y, ifb.h1, ifb.h2}, 3'b111);

        wr(4'd1, 16'h8000, 1'b1);
        wr(4'd2, 16'h8000, 1'b1);
        wr(4'd0, 16'h7FFF, 1'b1);
        run(16'h8000, 16'h8000);
        chk("ext_h1_ge0", ifa.h1, 1);
        chk("ext_h1_ge1", ifb.h1, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("sb0_drain", q0.size(), 0);
        chk("sb1_drain", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
